// File: rtl/vfr_bank_scheduler.sv
// Frame-sequencing scheduler for the video frame reader: per-frame go pulses, double-buffered bank swap,
// Avalon-MM register slave. Optional frame watchdog under `VFR_BANK_SCHEDULER_WATCHDOG_EN.
module vfr_bank_scheduler #(
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int WATCHDOG_CYCLES   = 4194304
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  slave_address,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_irq,
  output logic        go_bit,
  output logic        next_bank,
  input  logic        running,
  input  logic        frame_complete
);

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RUN  = 3'd2,
    ST_WAIT_DONE = 3'd3
  } state_t;

  state_t                       state, state_nxt;
  logic                         enable, irq_enable;
  logic                         commit_pending, pending_bank;
  logic [2:0]                   irq, irq_set, irq_clr;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count;
  logic                         frame_end, timeout;
  logic                         wr_ctrl, wr_commit, wr_irq;
  logic [31:0]                  rd_mux;
  logic                         unused_wd;

  assign unused_wd = ^slave_writedata[31:3];

  assign wr_ctrl   = slave_write && (slave_address == 3'd0);
  assign wr_commit = slave_write && (slave_address == 3'd2);
  assign wr_irq    = slave_write && (slave_address == 3'd3);
  assign frame_end = (state == ST_WAIT_DONE) && frame_complete;

`ifdef VFR_BANK_SCHEDULER_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES) + 1;
  logic [WDW-1:0] wd_cnt;
  logic           waiting;

  assign waiting = (state == ST_WAIT_RUN) || (state == ST_WAIT_DONE);
  assign timeout = waiting && (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                wd_cnt <= '0;
    else if (state_nxt != state) wd_cnt <= '0;
    else if (waiting)            wd_cnt <= wd_cnt + WDW'(1);
    else                         wd_cnt <= '0;
  end
`else
  localparam int wd_cycles_unused = WATCHDOG_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_STOPPED;
    else          state <= state_nxt;
  end

  // A disable never aborts a frame in flight; only frame end or timeout leaves WAIT_DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOPPED:   if (enable) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_RUN;
      ST_WAIT_RUN:  if (running) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (frame_complete) state_nxt = enable ? ST_ISSUE : ST_STOPPED;
      default:      state_nxt = ST_STOPPED;
    endcase
    if (timeout) state_nxt = ST_STOPPED;
  end

  assign go_bit = (state == ST_ISSUE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable     <= 1'b0;
      irq_enable <= 1'b0;
    end else begin
      if (wr_ctrl) {irq_enable, enable} <= slave_writedata[1:0];
      if (timeout) enable <= 1'b0;
    end
  end

  // Swap consumes the pre-write pending bank; a same-cycle commit re-arms for the next boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_bank      <= 1'b0;
      pending_bank   <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      if (frame_end && commit_pending) begin
        next_bank      <= pending_bank;
        commit_pending <= 1'b0;
      end
      if (wr_commit) begin
        pending_bank   <= slave_writedata[0];
        commit_pending <= 1'b1;
      end
    end
  end

  assign irq_set = {timeout, frame_end && commit_pending, frame_end};
  assign irq_clr = wr_irq ? slave_writedata[2:0] : 3'b000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq         <= 3'b000;
      frame_count <= '0;
      slave_irq   <= 1'b0;
    end else begin
      irq       <= (irq & ~irq_clr) | irq_set;
      slave_irq <= irq_enable && (|irq);
      if (frame_end) frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
    end
  end

  // timeout_flag tracks IRQ.timeout, so clearing that bit clears the status flag too.
  always_comb begin
    rd_mux = 32'd0;
    case (slave_address)
      3'd0: rd_mux = {30'd0, irq_enable, enable};
      3'd1: rd_mux = {25'd0, state, irq[2], commit_pending, next_bank, running};
      3'd3: rd_mux = {29'd0, irq};
      3'd4: rd_mux = 32'(frame_count);
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        slave_readdata <= 32'd0;
    else if (slave_read) slave_readdata <= rd_mux;
  end

endmodule
